// File: rtl/design_switch_sequencer.sv
// Debounced design selector: hands one of 12 designs the chip select through a
// quiesce / reset-hold / warm-up sequence before enabling its GPIO pass-through.
module design_switch_sequencer #(
  parameter int STABLE_CYCLES = 4,
  parameter int RST_HOLD      = 8,
  parameter int OUT_DELAY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_sel,
  output logic [3:0]  active_sel,
  output logic [12:1] designs_ncs,
  output logic [12:1] designs_n_rst,
  output logic        gpio_en,
  output logic        busy
);

  localparam int CW = 4;
  localparam int TW = 8;

  typedef enum logic [2:0] {IDLE, RUN, QUIESCE, HOLD, WARM} state_t;

  function automatic logic [12:1] sel_mask(input logic [3:0] sel);
    logic [12:1] m;
    m = '0;
    for (int i = 1; i <= 12; i++) m[i] = (sel == 4'(i));
    return m;
  endfunction

  logic [3:0]    req_norm;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accepted;

  state_t        state_q;
  logic [3:0]    target_q;
  logic [3:0]    active_q;
  logic [TW-1:0] timer_q;
  logic [12:1]   ncs_q;
  logic [12:1]   nrst_q;
  logic          gpio_q;
  logic          busy_q;

  // Debounce: a request only counts once it has held for STABLE_CYCLES edges
  always_comb begin
    req_norm = (req_sel >= 4'd1 && req_sel <= 4'd12) ? req_sel : 4'd0;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    if (req_norm != cand_q) begin
      cand_d = req_norm;
      cnt_d  = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign accepted = (cnt_q == CW'(STABLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      active_q <= '0;
      timer_q  <= '0;
      ncs_q    <= '1;
      nrst_q   <= '0;
      gpio_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          // GPIO, chip selects and resets all drop together on leaving RUN
          if (accepted && cand_q != active_q) begin
            state_q  <= QUIESCE;
            target_q <= cand_q;
            gpio_q   <= 1'b0;
            ncs_q    <= '1;
            nrst_q   <= '0;
            busy_q   <= 1'b1;
          end
        end
        QUIESCE: begin
          if (target_q == 4'd0) begin
            state_q  <= IDLE;
            active_q <= '0;
            busy_q   <= 1'b0;
          end else begin
            state_q  <= HOLD;
            active_q <= target_q;
            ncs_q    <= ~sel_mask(target_q);
            timer_q  <= TW'(RST_HOLD - 1);
          end
        end
        HOLD: begin
          if (timer_q == '0) begin
            state_q <= WARM;
            nrst_q  <= sel_mask(target_q);
            timer_q <= TW'(OUT_DELAY - 1);
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        WARM: begin
          if (timer_q == '0) begin
            state_q <= RUN;
            gpio_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active_sel    = active_q;
  assign designs_ncs   = ncs_q;
  assign designs_n_rst = nrst_q;
  assign gpio_en       = gpio_q;
  assign busy          = busy_q;

endmodule
